a25_wb_arbiter: RTL and testbench
=================================

// Module: a25_wb_arbiter
// PURPOSE
//  Two-master Wishbone arbiter for the a25 bus interface: shares one Wishbone master port between the
//  instruction-cache (m0) and data-cache (m1) requesters. Grants the bus round-robin and holds the
//  grant for a whole single or 4-beat burst transaction. Sequences beat addresses and the final release.
//  Sits between the caches and the a25_wishbone bus FSM.
// PARAMETERS
//  DATA_W          128   Wishbone data width in bits; SEL width = DATA_W/8
//  TIMEOUT_CYCLES  1000  cycles without ack before forced abort (used only with A25_WB_ARB_TIMEOUT_EN)
// PORTS
//  i_clk        in   1         clock, all logic on rising edge
//  i_rst        in   1         asynchronous, active-high reset
//  i_mN_stb     in   1         master N (N=0,1) request; held high until its last ack
//  i_mN_burst   in   1         1 = 4-beat burst, 0 = single beat; sampled at grant
//  i_mN_we      in   1         write enable; sampled at grant
//  i_mN_adr     in   32        start address; sampled at grant
//  i_mN_sel     in   DATA_W/8  byte selects; passed through while granted
//  i_mN_wdat    in   DATA_W    write data; passed through while granted
//  o_mN_ack     out  1         per-beat ack to master N
//  o_mN_err     out  1         error/abort termination to master N
//  o_mN_rdat    out  DATA_W    read data = i_wb_dat, gated to zero when not granted
//  o_wb_cyc     out  1         Wishbone cycle
//  o_wb_stb     out  1         Wishbone strobe
//  o_wb_we      out  1         Wishbone write enable
//  o_wb_adr     out  32        Wishbone beat address
//  o_wb_sel     out  DATA_W/8  Wishbone byte selects
//  o_wb_dat     out  DATA_W    Wishbone write data
//  i_wb_dat     in   DATA_W    Wishbone read data
//  i_wb_ack     in   1         Wishbone ack
//  i_wb_err     in   1         Wishbone error
// BEHAVIOUR
//  - Reset: state ARB_IDLE, priority pointer = m0, beat count 0; o_wb_cyc/stb/we = 0, o_wb_adr/sel/dat = 0,
//    all o_mN_ack/err = 0, o_mN_rdat = 0. Reset mid-transaction aborts immediately; no ack emitted.
//  - States: ARB_IDLE -> ARB_GRANT0 or ARB_GRANT1 -> ARB_RELEASE -> ARB_IDLE.
//  - ARB_IDLE: if only one stb is high, grant it; if both are high, grant the priority master.
//    Registered decision: stb seen in cycle n -> o_wb_cyc/stb high in cycle n+1.
//    At grant, latch we, adr[31:4], burst; beat count = 3 (burst) or 0 (single).
//  - ARB_GRANTx: o_wb_cyc = o_wb_stb = 1.
//    o_wb_adr = {latched adr[31:4] + beat index, 4'h0}; beat index counts 0..3 with carry into adr[31:6].
//    o_wb_sel/dat are combinational from master x. o_mx_ack = i_wb_ack (combinational); other master's ack = 0.
//    On each ack: beat index +1. Ack with beat count 0 -> ARB_RELEASE; otherwise beat count -1.
//  - i_wb_err in ARB_GRANTx: o_mx_err = 1 for that cycle, o_mx_ack = 0, -> ARB_RELEASE; remaining beats dropped.
//  - ARB_RELEASE: one cycle, cyc/stb = 0 (bus turnaround), priority pointer -> the master not just served,
//    -> ARB_IDLE. Consecutive grants are therefore >= 2 cycles apart.
//  - stb deasserted by the granted master mid-transaction: protocol error, ignored; all beats still run.
//  - i_wb_ack/i_wb_err outside ARB_GRANTx: ignored. Simultaneous ack and err: err wins.
// CONFIGURATION
//  - A25_WB_ARB_TIMEOUT_EN defined: a 10-bit+ watchdog counter clears on grant and on each ack and
//    increments every ARB_GRANTx cycle. At TIMEOUT_CYCLES: o_mx_err pulses 1 cycle, cyc/stb drop,
//    -> ARB_RELEASE. Counter reset value 0.
//  - Undefined: no counter; o_mN_err driven only by i_wb_err; the arbiter waits indefinitely.
// TESTING
//  1. m0 single read at 0x100, ack after 2 cycles -> cyc/stb 1 cycle after stb; adr 0x100; one o_m0_ack;
//     o_m0_rdat = i_wb_dat; 1 release cycle.
//  2. m1 burst write at 0x2000 -> adr 0x2000, 0x2010, 0x2020, 0x2030 on successive acks; 4 o_m1_ack; then release.
//  3. m0 and m1 stb in the same cycle from reset -> m0 served first, then m1;
//     repeat with both held -> grants alternate 0,1,0,1.
//  4. i_wb_err on beat 2 of an m1 burst -> o_m1_err 1 cycle; no further acks; bus released; next stb granted.
//  5. Assert i_rst during beat 1 of a burst -> all outputs 0 asynchronously; state IDLE; priority m0.
//  6. With A25_WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> o_m0_err at 8th granted cycle,
//     cyc drops; without the macro, cyc stays high.

Source files
------------

// File: rtl/a25_wb_arbiter.sv
// rtl/a25_wb_arbiter.sv - round-robin two-master Wishbone arbiter with single/4-beat burst sequencing
// Define A25_WB_ARB_TIMEOUT_EN to add a no-ack watchdog that aborts the granted transaction.
module a25_wb_arbiter #(
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_m0_stb,
  input  logic                i_m0_burst,
  input  logic                i_m0_we,
  input  logic [31:0]         i_m0_adr,
  input  logic [DATA_W/8-1:0] i_m0_sel,
  input  logic [DATA_W-1:0]   i_m0_wdat,
  output logic                o_m0_ack,
  output logic                o_m0_err,
  output logic [DATA_W-1:0]   o_m0_rdat,
  input  logic                i_m1_stb,
  input  logic                i_m1_burst,
  input  logic                i_m1_we,
  input  logic [31:0]         i_m1_adr,
  input  logic [DATA_W/8-1:0] i_m1_sel,
  input  logic [DATA_W-1:0]   i_m1_wdat,
  output logic                o_m1_ack,
  output logic                o_m1_err,
  output logic [DATA_W-1:0]   o_m1_rdat,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [31:0]         o_wb_adr,
  output logic [DATA_W/8-1:0] o_wb_sel,
  output logic [DATA_W-1:0]   o_wb_dat,
  input  logic [DATA_W-1:0]   i_wb_dat,
  input  logic                i_wb_ack,
  input  logic                i_wb_err
);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT0  = 2'd1,
    ARB_GRANT1  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  arb_state_t  state, state_nxt;
  logic        prio;        // 0: m0 wins a tie, 1: m1 wins a tie
  logic [1:0]  beat_cnt;
  logic [1:0]  beat_idx;
  logic        lat_we;
  logic [27:0] lat_adr;
  logic        grant0, grant1;
  logic        granted0, granted1, granted;
  logic        timeout, term_err, beat_ack;

  // Low address nibble is always zero on a 128-bit bus
  logic unused_adr_lo;
  assign unused_adr_lo = ^{i_m0_adr[3:0], i_m1_adr[3:0]};

  assign granted0 = (state == ARB_GRANT0);
  assign granted1 = (state == ARB_GRANT1);
  assign granted  = granted0 | granted1;

`ifdef A25_WB_ARB_TIMEOUT_EN
  localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W   = (WD_RAW > 10) ? WD_RAW : 10;

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt <= '0;
    end else if (!granted || i_wb_ack) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th granted cycle without an ack
  assign timeout = granted && !i_wb_ack && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign term_err = granted & (i_wb_err | timeout);
  assign beat_ack = granted & i_wb_ack & ~i_wb_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (i_m0_stb && (!i_m1_stb || !prio)) begin
          state_nxt = ARB_GRANT0;
          grant0    = 1'b1;
        end else if (i_m1_stb) begin
          state_nxt = ARB_GRANT1;
          grant1    = 1'b1;
        end
      end
      ARB_GRANT0, ARB_GRANT1: begin
        if (term_err || (beat_ack && (beat_cnt == 2'd0))) begin
          state_nxt = ARB_RELEASE;
        end
      end
      ARB_RELEASE: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prio     <= 1'b0;
      beat_cnt <= 2'd0;
      beat_idx <= 2'd0;
      lat_we   <= 1'b0;
      lat_adr  <= 28'd0;
    end else begin
      if (grant0) begin
        lat_we   <= i_m0_we;
        lat_adr  <= i_m0_adr[31:4];
        beat_cnt <= i_m0_burst ? 2'd3 : 2'd0;
        beat_idx <= 2'd0;
      end else if (grant1) begin
        lat_we   <= i_m1_we;
        lat_adr  <= i_m1_adr[31:4];
        beat_cnt <= i_m1_burst ? 2'd3 : 2'd0;
        beat_idx <= 2'd0;
      end else if (beat_ack) begin
        beat_idx <= beat_idx + 2'd1;
        if (beat_cnt != 2'd0) begin
          beat_cnt <= beat_cnt - 2'd1;
        end
      end
      // Hand the tie-break to whichever master was not just served
      if (granted && (state_nxt == ARB_RELEASE)) begin
        prio <= granted0;
      end
    end
  end

  assign o_wb_cyc = granted;
  assign o_wb_stb = granted;
  assign o_wb_we  = granted & lat_we;
  assign o_wb_adr = granted ? {lat_adr + {26'd0, beat_idx}, 4'h0} : 32'd0;
  assign o_wb_sel = granted0 ? i_m0_sel  : (granted1 ? i_m1_sel  : '0);
  assign o_wb_dat = granted0 ? i_m0_wdat : (granted1 ? i_m1_wdat : '0);

  assign o_m0_ack  = granted0 & beat_ack;
  assign o_m1_ack  = granted1 & beat_ack;
  assign o_m0_err  = granted0 & term_err;
  assign o_m1_err  = granted1 & term_err;
  assign o_m0_rdat = granted0 ? i_wb_dat : '0;
  assign o_m1_rdat = granted1 ? i_wb_dat : '0;

endmodule

// File: tb/tb_a25_wb_arbiter.sv
// tb/tb_a25_wb_arbiter.sv - directed self-checking bench for a25_wb_arbiter
module tb_a25_wb_arbiter;

  localparam int DATA_W = 128;
  localparam int SEL_W  = DATA_W / 8;

  localparam logic [SEL_W-1:0]  SEL0  = 16'h00FF;
  localparam logic [SEL_W-1:0]  SEL1  = 16'hFF00;
  localparam logic [DATA_W-1:0] WDAT0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [DATA_W-1:0] WDAT1 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_stb, m0_burst, m0_we;
  logic [31:0]       m0_adr;
  logic [SEL_W-1:0]  m0_sel;
  logic [DATA_W-1:0] m0_wdat;
  logic              m0_ack, m0_err;
  logic [DATA_W-1:0] m0_rdat;
  logic              m1_stb, m1_burst, m1_we;
  logic [31:0]       m1_adr;
  logic [SEL_W-1:0]  m1_sel;
  logic [DATA_W-1:0] m1_wdat;
  logic              m1_ack, m1_err;
  logic [DATA_W-1:0] m1_rdat;
  logic              wb_cyc, wb_stb, wb_we;
  logic [31:0]       wb_adr;
  logic [SEL_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_dat_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack, wb_err;

  int n_chk = 0;
  int n_err = 0;

  a25_wb_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_stb(m0_stb), .i_m0_burst(m0_burst), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
    .i_m0_sel(m0_sel), .i_m0_wdat(m0_wdat), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .o_m0_rdat(m0_rdat),
    .i_m1_stb(m1_stb), .i_m1_burst(m1_burst), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
    .i_m1_sel(m1_sel), .i_m1_wdat(m1_wdat), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_m1_rdat(m1_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_sel(wb_sel), .o_wb_dat(wb_dat_o), .i_wb_dat(wb_dat_i),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input logic burst, input logic we, input logic [31:0] adr);
    if (m == 0) begin
      m0_burst = burst; m0_we = we; m0_adr = adr; m0_stb = 1'b1;
    end else begin
      m1_burst = burst; m1_we = we; m1_adr = adr; m1_stb = 1'b1;
    end
  endtask

  task automatic wait_cyc();
    for (int k = 0; k < 10; k++) begin
      if (wb_cyc) break;
      tick();
    end
    chk("grant_wait", wb_cyc, 1'b1);
  endtask

  // Serve one transaction of master m, checking beat addresses, acks and the release cycle
  task automatic serve(input int m, input int nbeats, input logic [31:0] base,
                       input logic we, input bit drop);
    logic [DATA_W-1:0] rd;
    wait_cyc();
    chk("sel", wb_sel, (m == 0) ? SEL0 : SEL1);
    chk("wdat", wb_dat_o, (m == 0) ? WDAT0 : WDAT1);
    chk("we", wb_we, we);
    for (int i = 0; i < nbeats; i++) begin
      chk("beat_adr", wb_adr, base + 32'(16 * i));
      rd = {$urandom, $urandom, $urandom, $urandom};
      wb_dat_i = rd;
      wb_ack = 1'b1;
      #1;
      chk("ack_own", (m == 0) ? m0_ack : m1_ack, 1'b1);
      chk("ack_other", (m == 0) ? m1_ack : m0_ack, 1'b0);
      chk("rdat_own", (m == 0) ? m0_rdat : m1_rdat, rd);
      chk("rdat_other", (m == 0) ? m1_rdat : m0_rdat, '0);
      tick();
      wb_ack = 1'b0;
      if (drop && (i == nbeats - 1)) begin
        if (m == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
      end
    end
    chk("release_cyc", wb_cyc, 1'b0);
    chk("release_stb", wb_stb, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m0_stb = 0; m0_burst = 0; m0_we = 0; m0_adr = 0; m0_sel = SEL0; m0_wdat = WDAT0;
    m1_stb = 0; m1_burst = 0; m1_we = 0; m1_adr = 0; m1_sel = SEL1; m1_wdat = WDAT1;
    wb_dat_i = 128'hDEAD_BEEF; wb_ack = 1'b1; wb_err = 1'b0;
    tick();
    tick();
    // Reset state, with bus ack/data active to show nothing leaks through
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_adr", wb_adr, 32'd0);
    chk("rst_sel", wb_sel, '0);
    chk("rst_dat", wb_dat_o, '0);
    chk("rst_ack", {m0_ack, m1_ack, m0_err, m1_err}, 4'd0);
    chk("rst_rdat", m0_rdat | m1_rdat, '0);
    wb_ack = 1'b0;
    rst = 1'b0;
    tick();

    // 1: m0 single read, registered grant, ack after two granted cycles
    req(0, 1'b0, 1'b0, 32'h100);
    #1;
    chk("t1_no_comb_grant", wb_cyc, 1'b0);
    tick();
    chk("t1_cyc", wb_cyc, 1'b1);
    chk("t1_adr", wb_adr, 32'h100);
    tick();
    chk("t1_hold", wb_cyc, 1'b1);
    serve(0, 1, 32'h100, 1'b0, 1'b1);
    tick();
    chk("t1_idle", wb_cyc, 1'b0);

    // 2: m1 burst write
    req(1, 1'b1, 1'b1, 32'h2000);
    serve(1, 4, 32'h2000, 1'b1, 1'b1);
    tick();

    // 3: simultaneous requests from reset, then alternation while both held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req(0, 1'b0, 1'b0, 32'h300);
    req(1, 1'b0, 1'b0, 32'h400);
    serve(0, 1, 32'h300, 1'b0, 1'b0);
    serve(1, 1, 32'h400, 1'b0, 1'b0);
    serve(0, 1, 32'h300, 1'b0, 1'b0);
    serve(1, 1, 32'h400, 1'b0, 1'b0);
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    tick();
    tick();

    // 4: error on beat index 2 of an m1 burst, err wins over a simultaneous ack
    req(1, 1'b1, 1'b0, 32'h5000);
    wait_cyc();
    for (int i = 0; i < 2; i++) begin
      chk("t4_adr", wb_adr, 32'h5000 + 32'(16 * i));
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
    end
    chk("t4_adr2", wb_adr, 32'h5020);
    wb_err = 1'b1;
    wb_ack = 1'b1;
    #1;
    chk("t4_err", m1_err, 1'b1);
    chk("t4_ack_blocked", m1_ack, 1'b0);
    tick();
    wb_err = 1'b0;
    m1_stb = 1'b0;
    chk("t4_err_pulse", m1_err, 1'b0);
    chk("t4_release", wb_cyc, 1'b0);
    chk("t4_late_ack", m1_ack, 1'b0);
    wb_ack = 1'b0;
    req(0, 1'b0, 1'b1, 32'h600);
    serve(0, 1, 32'h600, 1'b1, 1'b1);
    tick();

    // 5: reset during beat 1 of an m1 burst while the tie-break points at m1
    req(1, 1'b1, 1'b0, 32'h7000);
    wait_cyc();
    wb_ack = 1'b1;
    tick();
    chk("t5_adr1", wb_adr, 32'h7010);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_cyc", wb_cyc, 1'b0);
    chk("t5_stb", wb_stb, 1'b0);
    chk("t5_adr", wb_adr, 32'd0);
    chk("t5_ack", m1_ack, 1'b0);
    chk("t5_rdat", m1_rdat, '0);
    tick();
    rst = 1'b0;
    wb_ack = 1'b0;
    req(0, 1'b0, 1'b0, 32'h800);
    serve(0, 1, 32'h800, 1'b0, 1'b1);
    serve(1, 4, 32'h7000, 1'b0, 1'b1);
    tick();

    // 6: no ack at all
    req(0, 1'b0, 1'b0, 32'h900);
    wait_cyc();
`ifdef A25_WB_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      chk("t6_no_early_err", m0_err, 1'b0);
      chk("t6_cyc_held", wb_cyc, 1'b1);
      tick();
    end
    chk("t6_timeout_err", m0_err, 1'b1);
    tick();
    m0_stb = 1'b0;
    chk("t6_cyc_drop", wb_cyc, 1'b0);
    chk("t6_err_pulse", m0_err, 1'b0);
`else
    for (int k = 0; k < 20; k++) begin
      chk("t6_cyc_waits", wb_cyc, 1'b1);
      chk("t6_no_err", m0_err, 1'b0);
      tick();
    end
    serve(0, 1, 32'h900, 1'b0, 1'b1);
`endif
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
